// File: rtl/laser_gun_pkg.sv
// Shared types and constants for the laser gun controller.
//   state_t : 2-bit FSM state encoding (IDLE, FIRE, COOLDOWN, RELOAD)
//   AMMO_W  : width of the ammo counter (magazine sizes 1..15)
//   max3    : helper used to size the shared state timer
package laser_gun_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    COOLDOWN = 2'd2,
    RELOAD   = 2'd3
  } state_t;

  localparam int AMMO_W = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, debounced level
// and a one-cycle rising-edge pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   btn        : raw asynchronous button input (active-high)
//   level      : debounced level, changes after DEBOUNCE_CYCLES equal samples
//   rise       : one-cycle pulse in the first cycle level reads high
// After reset the block is disarmed: it first has to see the button stably
// released for DEBOUNCE_CYCLES samples, so a button held through reset never
// produces a rise until it is released and pressed again.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          differ;

  // Disarmed: count released samples. Armed: count samples that disagree
  // with the current debounced level.
  assign differ = armed ? (sync != level) : ~sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      rise <= 1'b0;
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt <= '0;
        if (armed) begin
          level <= sync;
          rise  <= sync;
        end else begin
          armed <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/laser_gun_controller.sv
// Laser gun controller: debounced trigger/reload buttons drive a four-state
// FSM (IDLE, FIRE, COOLDOWN, RELOAD) timed by one shared down-counter.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   trigger_btn : raw trigger button (active-high)
//   reload_btn  : raw reload button (active-high)
//   laser_on    : registered laser drive, high only in FIRE
//   shot_fired  : one-cycle pulse on the first laser_on cycle of a shot
//   ammo        : rounds remaining
//   empty       : ammo == 0
//   busy        : FSM is not in IDLE
// Build option LASER_GUN_AUTOFIRE_EN: a trigger still held when COOLDOWN
// ends fires again immediately (if ammo remains). Default: one shot per press.
module laser_gun_controller
  import laser_gun_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 500000,
  parameter int COOLDOWN_CYCLES = 2500000,
  parameter int RELOAD_CYCLES   = 10000000,
  parameter int MAG_SIZE        = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger_btn,
  input  logic              reload_btn,
  output logic              laser_on,
  output logic              shot_fired,
  output logic [AMMO_W-1:0] ammo,
  output logic              empty,
  output logic              busy
);

  localparam int MAX_CYC = max3(PULSE_CYCLES, COOLDOWN_CYCLES, RELOAD_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Counter holds N-1 on state entry and leaves the state when it hits 0.
  localparam logic [CNT_W-1:0]  PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  COOL_LOAD   = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RELOAD_LOAD = CNT_W'(RELOAD_CYCLES - 1);
  localparam logic [AMMO_W-1:0] MAG_FULL    = AMMO_W'(MAG_SIZE);

  logic trig_level, trig_rise;
  logic reload_level, reload_rise;
  logic unused_levels;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (trigger_btn),
    .level (trig_level),
    .rise  (trig_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reload_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (reload_btn),
    .level (reload_level),
    .rise  (reload_rise)
  );

  // The reload level is never needed; the trigger level only with autofire.
  assign unused_levels = trig_level ^ reload_level;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [AMMO_W-1:0]  ammo_next;
  logic               fire_start;
  logic               laser_d;

  // State register (also carries timer, ammo and the registered outputs).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ammo       <= MAG_FULL;
      laser_on   <= 1'b0;
      shot_fired <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      ammo       <= ammo_next;
      laser_on   <= laser_d;
      shot_fired <= fire_start;
    end
  end

  // Next-state logic. Edges outside IDLE are simply not looked at, so they
  // are dropped rather than queued.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ammo_next  = ammo;
    fire_start = 1'b0;
    case (state)
      IDLE: begin
        if (trig_rise && (ammo != '0)) begin
          fire_start = 1'b1;
        end else if (reload_rise && (ammo != MAG_FULL)) begin
          state_next = RELOAD;
          cnt_next   = RELOAD_LOAD;
        end
      end
      FIRE: begin
        if (cnt == '0) begin
          state_next = COOLDOWN;
          cnt_next   = COOL_LOAD;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      COOLDOWN: begin
        if (cnt == '0) begin
          state_next = IDLE;
          cnt_next   = '0;
`ifdef LASER_GUN_AUTOFIRE_EN
          if (trig_level && (ammo != '0)) begin
            fire_start = 1'b1;
          end
`endif
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RELOAD: begin
        if (cnt == '0) begin
          state_next = IDLE;
          cnt_next   = '0;
          ammo_next  = MAG_FULL;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (fire_start) begin
      state_next = FIRE;
      cnt_next   = PULSE_LOAD;
      ammo_next  = ammo - 1'b1;
    end
  end

  // Output logic: laser_on is registered from the next state so it is high
  // exactly in FIRE cycles and clears asynchronously with reset.
  always_comb begin
    laser_d = (state_next == FIRE);
    busy    = (state != IDLE);
    empty   = (ammo == '0);
  end

endmodule

// File: tb/tb_laser_gun_controller.sv
// Bench for laser_gun_controller (DEBOUNCE=4, PULSE=8, COOLDOWN=16,
// RELOAD=32, MAG=3). A behavioural model (sample-window debouncer and
// remaining-cycle counters for the gun) is compared with the DUT every
// cycle; a press table and hand sequences check the scenario-level results.
module tb_laser_gun_controller;

  localparam int DB = 4;
  localparam int P  = 8;
  localparam int C  = 16;
  localparam int R  = 32;
  localparam int M  = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trigger_btn = 1'b0;
  logic       reload_btn = 1'b0;
  logic       laser_on, shot_fired, empty, busy;
  logic [3:0] ammo;

  always #5 clk = ~clk;

  laser_gun_controller #(
    .DEBOUNCE_CYCLES (DB),
    .PULSE_CYCLES    (P),
    .COOLDOWN_CYCLES (C),
    .RELOAD_CYCLES   (R),
    .MAG_SIZE        (M)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger_btn (trigger_btn),
    .reload_btn  (reload_btn),
    .laser_on    (laser_on),
    .shot_fired  (shot_fired),
    .ammo        (ammo),
    .empty       (empty),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Debouncer: hist bit j = raw sample taken j edges ago (bit 2 is what the
  // synchronizer presents). The level flips when the last DB presented
  // samples all disagree with it; before that, DB released samples arm it.
  typedef struct packed {
    bit [31:0] hist;
    int        n;
    bit        armed;
    bit        level;
    bit        rise;
  } btn_m_t;

  function automatic btn_m_t db_step(input btn_m_t s, input bit b);
    int mask;
    int w;
    mask   = (1 << DB) - 1;
    s.hist = {s.hist[30:0], b};
    if (s.n < 1000) s.n++;
    w      = int'(s.hist >> 2) & mask;
    s.rise = 1'b0;
    if (s.n >= DB) begin
      if (!s.armed) begin
        if (w == 0) s.armed = 1'b1;
      end else if (!s.level && w == mask) begin
        s.level = 1'b1;
        s.rise  = 1'b1;
      end else if (s.level && w == 0) begin
        s.level = 1'b0;
      end
    end
    return s;
  endfunction

  btn_m_t     m_tr, m_rl;
  int         m_ammo, m_busy, m_laser, m_mode;   // mode: 0 none, 1 shot, 2 reload
  bit         m_shot;
  logic [3:0] exp_q[$];                          // ammo expected after each shot

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ammo = M; m_busy = 0; m_laser = 0; m_mode = 0; m_shot = 0;
      m_tr = '0; m_rl = '0;
      exp_q.delete();
    end else begin
      bit fire;
      fire   = 0;
      m_shot = 0;
      if (m_busy == 0) begin
        if (m_tr.rise && m_ammo > 0) fire = 1;
        else if (m_rl.rise && m_ammo < M) begin
          m_busy = R;
          m_mode = 2;
        end
      end else begin
        m_busy--;
        if (m_laser > 0) m_laser--;
        if (m_busy == 0) begin
          if (m_mode == 2) m_ammo = M;
`ifdef LASER_GUN_AUTOFIRE_EN
          if (m_mode == 1 && m_tr.level && m_ammo > 0) fire = 1;
`endif
          m_mode = 0;
        end
      end
      if (fire) begin
        m_ammo--;
        m_laser = P;
        m_busy  = P + C;
        m_mode  = 1;
        m_shot  = 1;
        exp_q.push_back(4'(m_ammo));
      end
      m_tr = db_step(m_tr, trigger_btn);
      m_rl = db_step(m_rl, reload_btn);
    end
  end

  // ---------------- scoreboard / monitors ----------------
  int shot_cnt = 0, laser_cnt = 0, busy_cnt = 0, cyc = 0;
  int last_shot_cyc = 0, shot_gap = 0;

  always @(negedge clk) begin
    cyc++;
    check("laser_on", int'(laser_on), int'(m_laser > 0));
    check("shot_fired", int'(shot_fired), int'(m_shot));
    check("ammo", int'(ammo), m_ammo);
    check("empty", int'(empty), int'(m_ammo == 0));
    check("busy", int'(busy), int'(m_busy > 0));
    if (laser_on) laser_cnt++;
    if (busy) busy_cnt++;
    if (shot_fired) begin
      shot_cnt++;
      shot_gap      = cyc - last_shot_cyc;
      last_shot_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_shot", 1, 0);
      else check("shot_ammo", int'(ammo), int'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit t, input bit r, input int hold);
    @(negedge clk);
    trigger_btn = t;
    reload_btn  = r;
    repeat (hold) @(negedge clk);
    trigger_btn = 1'b0;
    reload_btn  = 1'b0;
  endtask

  task automatic wait_shot(input int max_cyc, output bit found);
    found = 0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk);
      if (shot_fired) found = 1;
    end
  endtask

  // ---------------- press table ----------------
  typedef struct {
    bit trig;
    bit rel;
    int shots;
    int laser;
    int busy;
    int ammo;
    bit empty;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  s0, l0, b0;
    bit  found;

    vecs[0] = '{1, 0, 1, P, P + C, 2, 0};
    vecs[1] = '{1, 0, 1, P, P + C, 1, 0};
    vecs[2] = '{1, 0, 1, P, P + C, 0, 1};
    vecs[3] = '{1, 0, 0, 0, 0,     0, 1};   // empty: trigger ignored
    vecs[4] = '{0, 1, 0, 0, R,     3, 0};   // reload from empty
    vecs[5] = '{0, 1, 0, 0, 0,     3, 0};   // reload when full: ignored
    vecs[6] = '{1, 1, 1, P, P + C, 2, 0};   // both, ammo>0: trigger wins
    vecs[7] = '{1, 1, 1, P, P + C, 1, 0};
    vecs[8] = '{1, 0, 1, P, P + C, 0, 1};
    vecs[9] = '{1, 1, 0, 0, R,     3, 0};   // both, ammo==0: reload wins

    // reset state
    idle(3);
    check("rst_laser", int'(laser_on), 0);
    check("rst_shot", int'(shot_fired), 0);
    check("rst_ammo", int'(ammo), M);
    check("rst_empty", int'(empty), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(10);

    for (int i = 0; i < 10; i++) begin
      s0 = shot_cnt; l0 = laser_cnt; b0 = busy_cnt;
      press(vecs[i].trig, vecs[i].rel, 10);
      idle(50);
      check($sformatf("vec%0d_shots", i), shot_cnt - s0, vecs[i].shots);
      check($sformatf("vec%0d_laser", i), laser_cnt - l0, vecs[i].laser);
      check($sformatf("vec%0d_busy", i), busy_cnt - b0, vecs[i].busy);
      check($sformatf("vec%0d_ammo", i), int'(ammo), vecs[i].ammo);
      check($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].empty));
    end

    // bouncing trigger, then a short hold: exactly one shot
    s0 = shot_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); trigger_btn = ~trigger_btn;
      @(negedge clk);
    end
    trigger_btn = 1'b1;
    idle(12);
    trigger_btn = 1'b0;
    idle(50);
    check("bounce_shots", shot_cnt - s0, 1);
    check("bounce_ammo", int'(ammo), 2);

    // second press during COOLDOWN is discarded
    s0 = shot_cnt;
    @(negedge clk); trigger_btn = 1'b1;
    wait_shot(40, found);
    check("cool_first_shot", int'(found), 1);
    trigger_btn = 1'b0;
    idle(8);
    press(1, 0, 6);
    idle(50);
    check("cool_shots", shot_cnt - s0, 1);
    check("cool_ammo", int'(ammo), 1);

    // reset three cycles into FIRE with the trigger held through reset
    @(negedge clk); trigger_btn = 1'b1;
    wait_shot(40, found);
    check("rst_fire_shot", int'(found), 1);
    @(posedge clk);
    @(posedge clk);
    #1 check("laser_pre_rst", int'(laser_on), 1);
    #1 rst_n = 1'b0;
    #1 check("laser_async_off", int'(laser_on), 0);
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ammo", int'(ammo), M);
    s0 = shot_cnt;
    idle(30);
    check("held_thru_rst_shots", shot_cnt - s0, 0);
    trigger_btn = 1'b0;
    idle(20);
    press(1, 0, 10);
    idle(50);
    check("repress_shots", shot_cnt - s0, 1);
    check("repress_ammo", int'(ammo), 2);

    // held trigger: autofire only with the build option
    press(0, 1, 10);
    idle(50);
    check("af_reload_ammo", int'(ammo), M);
    s0 = shot_cnt;
    press(1, 0, 100);
    idle(50);
`ifdef LASER_GUN_AUTOFIRE_EN
    check("hold_shots", shot_cnt - s0, 3);
    check("hold_ammo", int'(ammo), 0);
    check("hold_gap", shot_gap, P + C);
`else
    check("hold_shots", shot_cnt - s0, 1);
    check("hold_ammo", int'(ammo), 2);
`endif

    // randomized bouncing buttons against the model
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      trigger_btn = ($urandom_range(0, 2) != 0);
      reload_btn  = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    trigger_btn = 1'b0;
    reload_btn  = 1'b0;
    idle(80);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
